// File: rtl/wb_arbiter_2to1_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant states,
// master indices and the wait-counter width.
package wb_arbiter_2to1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } arb_state_t;

  // Master 0 is the data-side port, master 1 the instruction-side port.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int CNT_W = 16;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts granted strobe cycles that have not been acknowledged and flags the
// cycle on which the slave has run out of time.
module wb_timeout_cnt
  import wb_arbiter_2to1_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  assign hit = en && (count == LIMIT);

  // Any cycle that is not a waiting strobe (idle, ack, stb low, timeout) restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && !hit) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Two-master, one-slave Wishbone arbiter with round-robin tie breaking,
// whole-cycle grants and a per-transfer ack timeout.
module wb_arbiter_2to1
  import wb_arbiter_2to1_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,

  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_data,
  input  logic              i_m0_we,
  input  logic [3:0]        i_m0_sel,
  input  logic              i_m0_stb,
  input  logic              i_m0_cyc,
  output logic [DATA_W-1:0] o_m0_data,
  output logic              o_m0_ack,
  output logic              o_m0_err,

  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_data,
  input  logic              i_m1_we,
  input  logic [3:0]        i_m1_sel,
  input  logic              i_m1_stb,
  input  logic              i_m1_cyc,
  output logic [DATA_W-1:0] o_m1_data,
  output logic              o_m1_ack,
  output logic              o_m1_err,

  output logic [ADDR_W-1:0] o_s_addr,
  output logic [DATA_W-1:0] o_s_data,
  output logic              o_s_we,
  output logic [3:0]        o_s_sel,
  output logic              o_s_stb,
  output logic              o_s_cyc,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_ack
);

  arb_state_t state, state_next;
  logic       last_grant, last_grant_next;
  logic       req0, req1;
  logic       gnt_stb;
  logic       cnt_en;
  logic       timeout;

  assign req0 = i_m0_cyc & i_m0_stb;
  assign req1 = i_m1_cyc & i_m1_stb;

  assign gnt_stb = ((state == GNT_M0) & i_m0_stb) | ((state == GNT_M1) & i_m1_stb);
  assign cnt_en  = gnt_stb & ~i_s_ack;

  wb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .en   (cnt_en),
    .hit  (timeout)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      last_grant <= M1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
    state_next      = state;
    last_grant_next = last_grant;
    o_s_addr        = '0;
    o_s_data        = '0;
    o_s_we          = 1'b0;
    o_s_sel         = '0;
    o_s_stb         = 1'b0;
    o_s_cyc         = 1'b0;
    o_m0_data       = '0;
    o_m0_ack        = 1'b0;
    o_m0_err        = 1'b0;
    o_m1_data       = '0;
    o_m1_ack        = 1'b0;
    o_m1_err        = 1'b0;

    case (state)
      IDLE: begin
        if (req0 && (!req1 || last_grant == M1)) begin
          state_next = GNT_M0;
        end else if (req1) begin
          state_next = GNT_M1;
        end
      end

      GNT_M0: begin
        o_s_addr  = i_m0_addr;
        o_s_data  = i_m0_data;
        o_s_we    = i_m0_we;
        o_s_sel   = i_m0_sel;
        o_s_stb   = i_m0_stb & ~timeout;
        o_s_cyc   = i_m0_cyc & ~timeout;
        o_m0_data = i_s_data;
        o_m0_ack  = i_s_ack;
        o_m0_err  = timeout;
        // A timed-out grant counts as served, so the other master wins the next tie.
        if (!i_m0_cyc || timeout) begin
          state_next      = IDLE;
          last_grant_next = M0;
        end
      end

      GNT_M1: begin
        o_s_addr  = i_m1_addr;
        o_s_data  = i_m1_data;
        o_s_we    = i_m1_we;
        o_s_sel   = i_m1_sel;
        o_s_stb   = i_m1_stb & ~timeout;
        o_s_cyc   = i_m1_cyc & ~timeout;
        o_m1_data = i_s_data;
        o_m1_ack  = i_s_ack;
        o_m1_err  = timeout;
        if (!i_m1_cyc || timeout) begin
          state_next      = IDLE;
          last_grant_next = M1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/wb_arbiter_2to1.md
WB_ARBITER_2TO1 -- requirements
Module: wb_arbiter_2to1

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles without ack before error; legal 2..65535.
REQ-004 SHALL have: i_clk  in  1  single clock, rising edge.
REQ-005 SHALL have: i_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have, for master k in {0,1}: i_mk_addr  in  ADDR_W; i_mk_data  in  DATA_W; i_mk_we  in  1; i_mk_sel  in  4; i_mk_stb  in  1; i_mk_cyc  in  1. These are the master's Wishbone request.
REQ-007 SHALL have, for master k: o_mk_data  out  DATA_W  read data; o_mk_ack  out  1; o_mk_err  out  1  timeout error.
REQ-008 SHALL have slave side: o_s_addr  out  ADDR_W; o_s_data  out  DATA_W; o_s_we  out  1; o_s_sel  out  4; o_s_stb  out  1; o_s_cyc  out  1; i_s_data  in  DATA_W; i_s_ack  in  1.
REQ-009 SHALL treat master 0 as the data-side bus interface and master 1 as the instruction-side bus interface.

Function
REQ-010 SHALL implement an FSM with states IDLE, GNT_M0 and GNT_M1, plus a 1-bit last-grant register.
REQ-011 SHALL move IDLE->GNT_Mk on the next edge when only master k has cyc&stb=1.
REQ-012 SHALL, when both masters request in IDLE, grant the master not recorded as last grant (round-robin); last-grant resets to M1, so M0 wins the first tie.
REQ-013 SHALL hold GNT_Mk while i_mk_cyc=1, independent of the other master; no pre-emption.
REQ-014 SHALL return to IDLE on the edge after i_mk_cyc=0 in GNT_Mk, update last-grant to k, and spend at least one IDLE cycle between grants.
REQ-015 SHALL drive o_s_addr/data/we/sel/stb/cyc combinationally from the granted master in GNT_Mk; all slave outputs SHALL be 0 in IDLE.
REQ-016 SHALL route i_s_ack to o_mk_ack and i_s_data to o_mk_data combinationally for the granted master only; the non-granted master SHALL see ack=0, err=0, data=0.
REQ-017 SHALL keep a 16-bit wait counter, cleared in IDLE, on any i_s_ack=1, and when stb=0; it SHALL increment each granted cycle with stb=1 and ack=0.
REQ-018 SHALL, when the counter equals TIMEOUT-1 and ack=0, assert o_mk_err for exactly that cycle, force o_s_stb=0 and o_s_cyc=0 on that cycle, clear the counter, and go to IDLE on the next edge.
REQ-019 SHALL give ack priority over timeout when ack arrives on the TIMEOUT-1 cycle: ack is passed, no err.
REQ-020 SHALL ignore i_s_ack in IDLE; it SHALL NOT reach either master.
REQ-021 SHALL add zero latency on the data/ack path; grant latency SHALL be one cycle from the request to slave stb.

Reset
REQ-022 SHALL, with i_rst_n=0 at any time including mid-transfer, immediately force state=IDLE, last-grant=M1, counter=0, and all outputs to 0.
REQ-023 SHALL resume arbitration on the first rising edge after i_rst_n deasserts.

Structure
REQ-024 SHALL place the state enum (IDLE, GNT_M0, GNT_M1) and the master-index constants in the shared bus package.
REQ-025 SHALL be a single module; the timeout counter is the only natural sub-module candidate, named wb_timeout_cnt (optional).

Verification
REQ-026 SHALL cover single M0 read: addr 0xEE, slave acks after 2 cycles with data 0xEE -> o_m0_ack for 1 cycle with o_m0_data=0xEE; o_m1_ack stays 0.
REQ-027 SHALL cover simultaneous requests after reset: M0 (0x100) and M1 (0x200) both request -> M0 is granted first; after M0 drops cyc, one IDLE cycle, then o_s_addr=0x200.
REQ-028 SHALL cover a second tie after an M1 grant: M0 is granted; a following tie after an M0 grant grants M1.
REQ-029 SHALL cover timeout: TIMEOUT=8, slave never acks -> o_m1_err=1 exactly on the 8th stb cycle with o_s_cyc=0 that cycle, then IDLE.
REQ-030 SHALL cover ack/timeout tie: ack on the TIMEOUT-1 cycle -> ack=1, err=0.
REQ-031 SHALL cover reset mid-transfer: i_rst_n=0 while in GNT_M0 with stb=1 -> all outputs 0 asynchronously; after release, a pending M1 request is granted.
